// File: rtl/cnt_evt_pkg.sv
// Shared constants and event-type encodings for the counter event-capture block.
package cnt_evt_pkg;

   localparam int unsigned DEPTH_DEFAULT = 4;
   localparam logic [7:0]  DROP_MAX      = 8'd255;

   typedef enum logic [1:0] {
      EVT_NONE = 2'b00,
      EVT_RCO  = 2'b01,
      EVT_LOAD = 2'b10,
      EVT_BOTH = 2'b11
   } evt_type_e;

   function automatic evt_type_e evt_code(input logic load, input logic rco);
      return evt_type_e'({load, rco});
   endfunction

endpackage

// File: rtl/cnt_evt_fifo.sv
// First-word-fall-through FIFO: head entry is visible on head_data with no read latency.
module cnt_evt_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             push_eff;
   logic             pop_eff;

   assign empty     = (count == '0);
   assign full      = (count == FULL_CNT);
   assign pop_eff   = pop && !empty;
   // A push into a full FIFO is accepted only when the head leaves on the same edge
   assign push_eff  = push && (!full || pop_eff);
   assign head_data = mem[rptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push_eff) begin
            mem[wptr] <= push_data;
            wptr      <= wptr + 1'b1;
         end
         if (pop_eff) begin
            rptr <= rptr + 1'b1;
         end
         if (push_eff && !pop_eff) begin
            count <= count + 1'b1;
         end else if (pop_eff && !push_eff) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/cnt_event_capture.sv
// Captures counter rco/load events with the current Q and mode into an FWFT FIFO,
// counting (saturating) events lost to a full FIFO.
module cnt_event_capture
   import cnt_evt_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEFAULT,
   parameter int unsigned W     = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cap_en,
   input  logic [W-1:0]           Q_32b,
   input  logic                   rco_32b,
   input  logic                   load_32b,
   input  logic [1:0]             mode,
   input  logic                   evt_ready,
   output logic                   evt_valid,
   output logic [W-1:0]           evt_data,
   output logic [1:0]             evt_type,
   output logic [1:0]             evt_mode,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic [7:0]             drop_cnt
);

   localparam int unsigned EW = W + 4;

   logic          evt_hit;
   logic          drop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [1:0]    type_code;
   logic [EW-1:0] push_entry;
   logic [EW-1:0] head_entry;

   assign type_code  = evt_code(load_32b, rco_32b);
   assign evt_hit    = cap_en && (rco_32b || load_32b);
   assign push_entry = {type_code, mode, Q_32b};
   // When full, only a same-edge pop makes room; full implies the head is valid
   assign drop       = evt_hit && fifo_full && !evt_ready;

   cnt_evt_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (reset),
      .push      (evt_hit),
      .push_data (push_entry),
      .pop       (evt_ready),
      .head_data (head_entry),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign evt_valid = !fifo_empty;
   assign evt_type  = head_entry[W+3:W+2];
   assign evt_mode  = head_entry[W+1:W];
   assign evt_data  = head_entry[W-1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drop_cnt <= '0;
      end else if (drop && (drop_cnt != DROP_MAX)) begin
         drop_cnt <= drop_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_cnt_event_capture.sv
// Directed table-driven bench for cnt_event_capture (DEPTH=4, W=32) plus reset/saturation sequences.
module tb_cnt_event_capture;

   logic        clk;
   logic        reset;
   logic        cap_en;
   logic [31:0] Q_32b;
   logic        rco_32b;
   logic        load_32b;
   logic [1:0]  mode;
   logic        evt_ready;
   logic        evt_valid;
   logic [31:0] evt_data;
   logic [1:0]  evt_type;
   logic [1:0]  evt_mode;
   logic [2:0]  fifo_count;
   logic [7:0]  drop_cnt;

   int unsigned checks;
   int unsigned failures;

   typedef struct {
      logic        cap;
      logic        rco;
      logic        load;
      logic [1:0]  md;
      logic [31:0] q;
      logic        rdy;
      logic        ev;
      logic [1:0]  et;
      logic [31:0] ed;
      logic [1:0]  em;
      logic [2:0]  cnt;
      logic [7:0]  dr;
   } vec_t;

   localparam int unsigned NV = 19;
   vec_t vecs [NV];

   cnt_event_capture #(
      .DEPTH (4),
      .W     (32)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cap_en     (cap_en),
      .Q_32b      (Q_32b),
      .rco_32b    (rco_32b),
      .load_32b   (load_32b),
      .mode       (mode),
      .evt_ready  (evt_ready),
      .evt_valid  (evt_valid),
      .evt_data   (evt_data),
      .evt_type   (evt_type),
      .evt_mode   (evt_mode),
      .fifo_count (fifo_count),
      .drop_cnt   (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic cap, input logic rco, input logic load,
                               input logic [1:0] md, input logic [31:0] q, input logic rdy,
                               input logic ev, input logic [1:0] et, input logic [31:0] ed,
                               input logic [1:0] em, input logic [2:0] cnt, input logic [7:0] dr);
      vec_t v;
      v.cap = cap; v.rco = rco; v.load = load; v.md = md; v.q = q; v.rdy = rdy;
      v.ev = ev; v.et = et; v.ed = ed; v.em = em; v.cnt = cnt; v.dr = dr;
      return v;
   endfunction

   task automatic drive(input logic cap, input logic rco, input logic load,
                        input logic [1:0] md, input logic [31:0] q, input logic rdy);
      cap_en = cap; rco_32b = rco; load_32b = load; mode = md; Q_32b = q; evt_ready = rdy;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);

      //               cap rco ld  mode   Q             rdy | ev et     data          em     cnt   drop
      vecs[0]  = mk(1, 1, 0, 2'b10, 32'hFFFF_FFFF, 0,  1, 2'b01, 32'hFFFF_FFFF, 2'b10, 3'd1, 8'd0);
      vecs[1]  = mk(0, 0, 0, 2'b00, 32'h0,         1,  0, 2'b00, 32'h0,         2'b00, 3'd0, 8'd0);
      vecs[2]  = mk(1, 1, 1, 2'b01, 32'h1234,      0,  1, 2'b11, 32'h1234,      2'b01, 3'd1, 8'd0);
      vecs[3]  = mk(0, 1, 0, 2'b00, 32'h55,        0,  1, 2'b11, 32'h1234,      2'b01, 3'd1, 8'd0);
      vecs[4]  = mk(0, 0, 1, 2'b10, 32'h66,        0,  1, 2'b11, 32'h1234,      2'b01, 3'd1, 8'd0);
      vecs[5]  = mk(0, 0, 0, 2'b00, 32'h0,         1,  0, 2'b00, 32'h0,         2'b00, 3'd0, 8'd0);
      vecs[6]  = mk(0, 0, 0, 2'b00, 32'h0,         1,  0, 2'b00, 32'h0,         2'b00, 3'd0, 8'd0);
      vecs[7]  = mk(1, 0, 1, 2'b11, 32'h77,        1,  1, 2'b10, 32'h77,        2'b11, 3'd1, 8'd0);
      vecs[8]  = mk(0, 0, 0, 2'b00, 32'h0,         1,  0, 2'b00, 32'h0,         2'b00, 3'd0, 8'd0);
      vecs[9]  = mk(1, 0, 1, 2'b00, 32'd1,         0,  1, 2'b10, 32'd1,         2'b00, 3'd1, 8'd0);
      vecs[10] = mk(1, 0, 1, 2'b00, 32'd2,         0,  1, 2'b10, 32'd1,         2'b00, 3'd2, 8'd0);
      vecs[11] = mk(1, 0, 1, 2'b00, 32'd3,         0,  1, 2'b10, 32'd1,         2'b00, 3'd3, 8'd0);
      vecs[12] = mk(1, 0, 1, 2'b00, 32'd4,         0,  1, 2'b10, 32'd1,         2'b00, 3'd4, 8'd0);
      vecs[13] = mk(1, 0, 1, 2'b00, 32'd5,         0,  1, 2'b10, 32'd1,         2'b00, 3'd4, 8'd1);
      vecs[14] = mk(1, 1, 0, 2'b01, 32'd9,         1,  1, 2'b10, 32'd2,         2'b00, 3'd4, 8'd1);
      vecs[15] = mk(0, 0, 0, 2'b00, 32'h0,         1,  1, 2'b10, 32'd3,         2'b00, 3'd3, 8'd1);
      vecs[16] = mk(0, 0, 0, 2'b00, 32'h0,         1,  1, 2'b10, 32'd4,         2'b00, 3'd2, 8'd1);
      vecs[17] = mk(0, 0, 0, 2'b00, 32'h0,         1,  1, 2'b01, 32'd9,         2'b01, 3'd1, 8'd1);
      vecs[18] = mk(0, 0, 0, 2'b00, 32'h0,         1,  0, 2'b00, 32'h0,         2'b00, 3'd0, 8'd1);

      // Reset state
      #1;
      check("rst_valid", {31'd0, evt_valid}, 32'd0);
      check("rst_count", {29'd0, fifo_count}, 32'd0);
      check("rst_drop",  {24'd0, drop_cnt}, 32'd0);
      check("rst_data",  evt_data, 32'd0);
      check("rst_type",  {30'd0, evt_type}, 32'd0);
      check("rst_mode",  {30'd0, evt_mode}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < NV; i++) begin
         if (i != 0) @(negedge clk);
         drive(vecs[i].cap, vecs[i].rco, vecs[i].load, vecs[i].md, vecs[i].q, vecs[i].rdy);
         @(posedge clk);
         #1;
         check($sformatf("v%0d_valid", i), {31'd0, evt_valid}, {31'd0, vecs[i].ev});
         check($sformatf("v%0d_count", i), {29'd0, fifo_count}, {29'd0, vecs[i].cnt});
         check($sformatf("v%0d_drop", i),  {24'd0, drop_cnt}, {24'd0, vecs[i].dr});
         if (vecs[i].ev) begin
            check($sformatf("v%0d_data", i), evt_data, vecs[i].ed);
            check($sformatf("v%0d_type", i), {30'd0, evt_type}, {30'd0, vecs[i].et});
            check($sformatf("v%0d_mode", i), {30'd0, evt_mode}, {30'd0, vecs[i].em});
         end
      end

      // Fill, then 300 more events with no consumer: drop_cnt goes 1 -> 255 and holds
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(1'b1, 1'b0, 1'b1, 2'b11, 32'hA0 + 32'(i), 1'b0);
      end
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         drive(1'b1, 1'b1, 1'b0, 2'b01, 32'h1000 + 32'(i), 1'b0);
      end
      @(posedge clk);
      #1;
      check("sat_drop",  {24'd0, drop_cnt}, 32'd255);
      check("sat_count", {29'd0, fifo_count}, 32'd4);
      check("sat_head",  evt_data, 32'hA0);
      check("sat_type",  {30'd0, evt_type}, 32'd2);
      check("sat_mode",  {30'd0, evt_mode}, 32'd3);

      // Asynchronous reset mid-stream, events still driven
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_count", {29'd0, fifo_count}, 32'd0);
      check("mid_rst_valid", {31'd0, evt_valid}, 32'd0);
      check("mid_rst_drop",  {24'd0, drop_cnt}, 32'd0);
      check("mid_rst_data",  evt_data, 32'd0);
      @(posedge clk);
      #1;
      check("rst_edge_count", {29'd0, fifo_count}, 32'd0);

      // First edge after release captures
      @(negedge clk);
      reset = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 2'b10, 32'hBEEF, 1'b0);
      @(posedge clk);
      #1;
      check("post_rst_count", {29'd0, fifo_count}, 32'd1);
      check("post_rst_data",  evt_data, 32'hBEEF);
      check("post_rst_type",  {30'd0, evt_type}, 32'd1);
      check("post_rst_mode",  {30'd0, evt_mode}, 32'd2);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cnt_event_capture.md
CNT_EVENT_CAPTURE -- requirements
Module: cnt_event_capture

Interface
REQ-001 SHALL expose parameter DEPTH, default 4, meaning FIFO entries (power of two, >= 2).
REQ-002 SHALL expose parameter W, default 32, meaning captured counter width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cap_en  input  1  capture enable; 0 blocks all pushes.
REQ-006 SHALL have port Q_32b  input  W  counter value from upstream counter.
REQ-007 SHALL have port rco_32b  input  1  counter ripple-carry-out pulse.
REQ-008 SHALL have port load_32b  input  1  counter load-indication pulse.
REQ-009 SHALL have port mode  input  2  counter mode in effect this cycle.
REQ-010 SHALL have port evt_ready  input  1  consumer accepts head entry.
REQ-011 SHALL have port evt_valid  output  1  head entry present (FIFO non-empty).
REQ-012 SHALL have port evt_data  output  W  captured Q of head entry.
REQ-013 SHALL have port evt_type  output  2  head event type: 01 rco, 10 load, 11 both.
REQ-014 SHALL have port evt_mode  output  2  mode captured with head entry.
REQ-015 SHALL have port fifo_count  output  clog2(DEPTH)+1  current occupancy.
REQ-016 SHALL have port drop_cnt  output  8  count of dropped events, saturating.

Function
REQ-017 Event cycle = rising clk where cap_en=1 and (rco_32b|load_32b)=1; entry {type={load_32b,rco_32b}, mode, Q_32b} SHALL be pushed.
REQ-018 Non-event cycles SHALL push nothing; rco_32b/load_32b are sampled per cycle, no edge detection, so a multi-cycle pulse pushes one entry per cycle.
REQ-019 FIFO SHALL be first-word-fall-through: evt_* outputs driven directly from head register, no added read latency.
REQ-020 Latency: event sampled at edge N into an empty FIFO SHALL give evt_valid=1 with that entry after edge N.
REQ-021 Pop SHALL occur at an edge where evt_valid=1 and evt_ready=1; evt_ready with evt_valid=0 SHALL have no effect.
REQ-022 Push and pop in the same edge SHALL both occur; fifo_count unchanged; legal at empty (push only effective) and full.
REQ-023 Push when full and no pop in the same edge SHALL be dropped, FIFO contents unchanged, drop_cnt incremented.
REQ-024 drop_cnt SHALL saturate at 255 and never wrap.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH; fifo_count SHALL range 0..DEPTH exactly.
REQ-026 evt_data/evt_type/evt_mode SHALL hold stable while evt_valid=1 and evt_ready=0.
REQ-027 Contents of evt_data/evt_type/evt_mode when evt_valid=0 are don't-care but SHALL not be X after reset (all zero).

Reset
REQ-028 reset=0 SHALL immediately clear pointers, fifo_count=0, evt_valid=0, evt_data=0, evt_type=0, evt_mode=0, drop_cnt=0.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries; no pop or push occurs on the edge where reset is low.
REQ-030 First push SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-031 Package cnt_evt_pkg SHALL hold DEPTH default, type encodings EVT_RCO=01, EVT_LOAD=10, EVT_BOTH=11, and drop-counter max 255.
REQ-032 Storage SHALL be a sub-module cnt_evt_fifo (parametric width/depth FWFT FIFO with push/pop/full/empty/count); cnt_event_capture holds event detection, entry packing, drop counter.
REQ-033 Block SHALL instantiate cleanly downstream of the 32-bit counter in the same top, sharing clk and reset.

Verification
REQ-034 Reset then rco_32b=1 for one cycle, Q_32b=32'hFFFF_FFFF, mode=2'b10, cap_en=1 -> next cycle evt_valid=1, evt_type=01, evt_data=FFFF_FFFF, evt_mode=10, fifo_count=1.
REQ-035 evt_ready=0, five consecutive load_32b pulses with Q=1..5 -> fifo_count=4, drop_cnt=1, then draining yields 1,2,3,4 in order, type 10.
REQ-036 FIFO full, simultaneous event (Q=9) and evt_ready=1 -> head popped, Q=9 stored at tail, fifo_count stays 4, drop_cnt unchanged.
REQ-037 rco_32b=1 and load_32b=1 same cycle -> single entry, evt_type=11; cap_en=0 with either pulse -> no entry.
REQ-038 300 events with FIFO full and evt_ready=0 -> drop_cnt=255 (saturated); reset low mid-stream -> fifo_count=0, evt_valid=0, drop_cnt=0 immediately.
